// File: rtl/fp_inv_sqrt_nr_multi.sv
// Folded fixed-point 1/sqrt(a) or sqrt(a): even-shift normalisation, seed LUT,
// Newton-Raphson on one shared multiplier, denormalisation with saturation.
module fp_inv_sqrt_nr_multi #(
  parameter int WIDTH     = 32,
  parameter int FRAC      = 16,
  parameter int ITERS     = 3,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [WIDTH-1:0]     a_in,
  input  logic                 mode_in,
  input  logic [TAG_WIDTH-1:0] tag_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic [WIDTH-1:0]     res_out,
  output logic                 err_out,
  output logic [TAG_WIDTH-1:0] tag_out,
  output logic                 valid_out,
  input  logic                 ready_in
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = $clog2(WIDTH) + 2;
  localparam int IW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic signed [WIDTH-1:0] THREE_HALF = WIDTH'(3 << (FRAC - 1));
  localparam logic signed [PW-1:0]    RND        = PW'(1) <<< (FRAC - 1);
  localparam logic signed [PW-1:0]    SAT_MAX    = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

  typedef enum logic [3:0] {
    S_IDLE, S_NORM, S_SEED, S_MUL_YY, S_MUL_MYY, S_MUL_UPD, S_SQRT_MUL, S_DENORM, S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [WIDTH-1:0]         r_a;
  logic                     r_mode;
  logic [TAG_WIDTH-1:0]     r_tag;
  logic signed [WIDTH-1:0]  r_m;
  logic signed [SW-1:0]     r_hs;
  logic signed [WIDTH-1:0]  r_y;
  logic signed [WIDTH-1:0]  r_t;
  logic [IW-1:0]            r_iter;
  logic                     r_err;
  logic [WIDTH-1:0]         r_res;
  logic                     r_err_out;
  logic [TAG_WIDTH-1:0]     r_tag_out;
  logic                     r_valid_out;

  logic                     w_bad;
  logic                     w_zero;
  logic [SW-1:0]            w_lead;
  logic signed [SW-1:0]     w_shift;
  logic signed [WIDTH-1:0]  w_m;
  logic [15:0]              w_lut;
  logic signed [WIDTH-1:0]  w_seed;
  logic signed [WIDTH-1:0]  w_op_a;
  logic signed [WIDTH-1:0]  w_op_b;
  logic signed [PW-1:0]     w_prod;
  logic signed [WIDTH-1:0]  w_rnd;
  logic signed [SW-1:0]     w_sh;
  logic signed [PW-1:0]     w_wide;
  logic signed [PW-1:0]     w_shl;
  logic signed [WIDTH-1:0]  w_den;

  assign w_zero = (r_a == '0);
  assign w_bad  = r_a[WIDTH-1] || (w_zero && !r_mode);

  // Even shift that places the leading one at bit FRAC or FRAC+1, i.e. m in [1,4).
  always_comb begin
    w_lead = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_a[i]) w_lead = SW'(i);
    end
    w_shift = $signed(SW'(FRAC)) - $signed(w_lead);
    if (w_shift[0]) w_shift = w_shift + SW'(1);
    w_m = (w_shift >= 0) ? (r_a << w_shift) : (r_a >> (-w_shift));
  end

  // Seed table in Q0.16: round(2^16 / sqrt(m_lo + 0.125)) for m_lo = idx/4.
  always_comb begin
    case (r_m[FRAC+1:FRAC-2])
      4'd4:    w_lut = 16'd61787;
      4'd5:    w_lut = 16'd55889;
      4'd6:    w_lut = 16'd51411;
      4'd7:    w_lut = 16'd47861;
      4'd8:    w_lut = 16'd44957;
      4'd9:    w_lut = 16'd42525;
      4'd10:   w_lut = 16'd40450;
      4'd11:   w_lut = 16'd38651;
      4'd12:   w_lut = 16'd37073;
      4'd13:   w_lut = 16'd35673;
      4'd14:   w_lut = 16'd34421;
      4'd15:   w_lut = 16'd33292;
      default: w_lut = 16'd65535;
    endcase
  end

  generate
    if (FRAC >= 16) begin : g_seed_up
      assign w_seed = WIDTH'(w_lut) << (FRAC - 16);
    end else begin : g_seed_dn
      assign w_seed = WIDTH'(w_lut) >> (16 - FRAC);
    end
  endgenerate

  assign w_prod = PW'(w_op_a) * PW'(w_op_b);
  assign w_rnd  = WIDTH'((w_prod + RND) >>> FRAC);

  // Undo normalisation; sqrt shifts the opposite way to 1/sqrt.
  always_comb begin
    w_sh   = r_mode ? -r_hs : r_hs;
    w_wide = PW'(r_y);
    w_shl  = '0;
    w_den  = r_y;
    if (w_sh >= 0) begin
      w_shl = w_wide <<< w_sh;
      w_den = (w_shl > SAT_MAX) ? SAT_MAX[WIDTH-1:0] : w_shl[WIDTH-1:0];
    end else begin
      w_den = r_y >>> (-w_sh);
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (valid_in) w_state_next = S_NORM;
      S_NORM:     w_state_next = (w_bad || w_zero) ? S_DONE : S_SEED;
      S_SEED:     w_state_next = S_MUL_YY;
      S_MUL_YY:   w_state_next = S_MUL_MYY;
      S_MUL_MYY:  w_state_next = S_MUL_UPD;
      S_MUL_UPD: begin
        if (r_iter == IW'(ITERS - 1)) w_state_next = r_mode ? S_SQRT_MUL : S_DENORM;
        else                          w_state_next = S_MUL_YY;
      end
      S_SQRT_MUL: w_state_next = S_DENORM;
      S_DENORM:   w_state_next = S_DONE;
      S_DONE:     if (r_valid_out && ready_in) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready_out = (r_state == S_IDLE);
    w_op_a    = r_y;
    w_op_b    = r_y;
    case (r_state)
      S_MUL_MYY:  begin w_op_a = r_m; w_op_b = r_t; end
      S_MUL_UPD:  begin w_op_a = r_y; w_op_b = THREE_HALF - (r_t >>> 1); end
      S_SQRT_MUL: begin w_op_a = r_m; w_op_b = r_y; end
      default:    begin w_op_a = r_y; w_op_b = r_y; end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_a         <= '0;
      r_mode      <= 1'b0;
      r_tag       <= '0;
      r_m         <= '0;
      r_hs        <= '0;
      r_y         <= '0;
      r_t         <= '0;
      r_iter      <= '0;
      r_err       <= 1'b0;
      r_res       <= '0;
      r_err_out   <= 1'b0;
      r_tag_out   <= '0;
      r_valid_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            r_a    <= a_in;
            r_mode <= mode_in;
            r_tag  <= tag_in;
            r_iter <= '0;
          end
        end
        S_NORM: begin
          r_m   <= w_m;
          r_hs  <= w_shift >>> 1;
          r_err <= w_bad;
          r_y   <= '0;
        end
        S_SEED:     r_y <= w_seed;
        S_MUL_YY:   r_t <= w_rnd;
        S_MUL_MYY:  r_t <= w_rnd;
        S_MUL_UPD: begin
          r_y    <= w_rnd;
          r_iter <= r_iter + IW'(1);
        end
        S_SQRT_MUL: r_y <= w_rnd;
        S_DENORM:   r_y <= w_den;
        S_DONE: begin
          // First DONE cycle loads the result; it is then held until taken.
          if (!r_valid_out) begin
            r_res       <= r_y;
            r_err_out   <= r_err;
            r_tag_out   <= r_tag;
            r_valid_out <= 1'b1;
          end else if (ready_in) begin
            r_valid_out <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_out   = r_res;
  assign err_out   = r_err_out;
  assign tag_out   = r_tag_out;
  assign valid_out = r_valid_out;

endmodule

// File: tb/tb_fp_inv_sqrt_nr_multi.sv
// Directed bench for fp_inv_sqrt_nr_multi: values, latency, errors,
// backpressure, back-to-back accepts and asynchronous reset mid-operation.
module tb_fp_inv_sqrt_nr_multi;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] a_in;
  logic        mode_in;
  logic [3:0]  tag_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] res_out;
  logic        err_out;
  logic [3:0]  tag_out;
  logic        valid_out;
  logic        ready_in;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  fp_inv_sqrt_nr_multi #(.WIDTH(32), .FRAC(16), .ITERS(3), .TAG_WIDTH(4)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .a_in      (a_in),
    .mode_in   (mode_in),
    .tag_in    (tag_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .res_out   (res_out),
    .err_out   (err_out),
    .tag_out   (tag_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic chk_tol(input string name, input logic [31:0] obs, input logic [31:0] exp,
                         input int tol);
    int   diff;
    logic ok;
    diff = int'(obs) - int'(exp);
    if (diff < 0) diff = -diff;
    ok = (diff <= tol);
    total++;
    assert (ok === 1'b1) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h+/-%0d", name, obs, exp, tol);
    end
  endtask

  // Accept one operand, wait for the result, optionally stall, then take it.
  task automatic run_op(input string name, input logic [31:0] a, input logic mode,
                        input logic [3:0] tag, input logic [31:0] exp_res, input int tol,
                        input logic exp_err, input int exp_lat, input int hold);
    int lat;
    @(negedge clk_in);
    chk({name, "_rdy_in"}, 64'(ready_out), 64'd1);
    a_in = a; mode_in = mode; tag_in = tag; valid_in = 1'b1;
    @(posedge clk_in);
    #1 valid_in = 1'b0;
    lat = 0;
    while (valid_out !== 1'b1 && lat < 100) begin
      @(posedge clk_in);
      #1;
      lat++;
    end
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk_tol({name, "_res"}, res_out, exp_res, tol);
    chk({name, "_err"}, 64'(err_out), 64'(exp_err));
    chk({name, "_tag"}, 64'(tag_out), 64'(tag));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk_in);
      #1;
      chk({name, "_hold_vld"}, 64'(valid_out), 64'd1);
      chk_tol({name, "_hold_res"}, res_out, exp_res, tol);
      chk({name, "_hold_tag"}, 64'(tag_out), 64'(tag));
      chk({name, "_hold_rdy"}, 64'(ready_out), 64'd0);
    end
    @(negedge clk_in);
    ready_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk({name, "_vld_clr"}, 64'(valid_out), 64'd0);
    chk({name, "_rdy_back"}, 64'(ready_out), 64'd1);
    ready_in = 1'b0;
  endtask

  logic [31:0] b2b_a   [4] = '{32'h0001_0000, 32'h0004_0000, 32'hFFFF_0000, 32'h0000_4000};
  logic [31:0] b2b_res [4] = '{32'h0001_0000, 32'h0000_8000, 32'h0000_0000, 32'h0002_0000};
  logic        b2b_err [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int          b2b_lat [4] = '{13, 13, 2, 13};

  initial begin
    int lat;
    rst_in = 1'b0; a_in = '0; mode_in = 1'b0; tag_in = '0; valid_in = 1'b0; ready_in = 1'b0;
    #12;
    chk("rst_ready", 64'(ready_out), 64'd1);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_res",   64'(res_out),   64'd0);
    chk("rst_err",   64'(err_out),   64'd0);
    chk("rst_tag",   64'(tag_out),   64'd0);
    @(negedge clk_in);
    rst_in = 1'b1;

    run_op("isq_1p0",    32'h0001_0000, 1'b0, 4'd3, 32'h0001_0000, 7, 1'b0, 13, 0);
    run_op("isq_0p25",   32'h0000_4000, 1'b0, 4'd1, 32'h0002_0000, 1, 1'b0, 13, 0);
    run_op("isq_0p5",    32'h0000_8000, 1'b0, 4'd2, 32'd92682,     7, 1'b0, 13, 0);
    run_op("isq_0p7",    32'h0000_B333, 1'b0, 4'd4, 32'd78330,     7, 1'b0, 13, 0);
    run_op("isq_3p7",    32'h0003_B333, 1'b0, 4'd5, 32'd34070,     7, 1'b0, 13, 0);
    run_op("isq_4p0",    32'h0004_0000, 1'b0, 4'd6, 32'h0000_8000, 1, 1'b0, 13, 0);
    run_op("isq_6p9",    32'h0006_E666, 1'b0, 4'd7, 32'd24949,     7, 1'b0, 13, 0);
    run_op("isq_lsb",    32'h0000_0001, 1'b0, 4'd8, 32'h0100_0000, 1, 1'b0, 13, 0);
    run_op("sqrt_2p0",   32'h0002_0000, 1'b1, 4'd9, 32'h0001_6A0A, 7, 1'b0, 14, 0);
    run_op("err_neg_m0", 32'hFFFF_0000, 1'b0, 4'hA, 32'h0,         0, 1'b1, 2,  0);
    run_op("err_neg_m1", 32'hFFFF_0000, 1'b1, 4'hB, 32'h0,         0, 1'b1, 2,  0);
    run_op("err_zero",   32'h0000_0000, 1'b0, 4'hC, 32'h0,         0, 1'b1, 2,  0);
    run_op("sqrt_zero",  32'h0000_0000, 1'b1, 4'hD, 32'h0,         0, 1'b0, 2,  0);
    run_op("backpress",  32'h0001_0000, 1'b0, 4'hE, 32'h0001_0000, 7, 1'b0, 13, 5);

    // valid_in and ready_in held high: each operand is taken on the first IDLE cycle.
    @(negedge clk_in);
    valid_in = 1'b1; ready_in = 1'b1; mode_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_in = b2b_a[k]; tag_in = 4'(k);
      @(posedge clk_in);
      #1;
      chk("b2b_busy", 64'(ready_out), 64'd0);
      lat = 0;
      while (valid_out !== 1'b1 && lat < 100) begin
        @(posedge clk_in);
        #1;
        lat++;
      end
      chk("b2b_lat", 64'(lat), 64'(b2b_lat[k]));
      chk("b2b_tag", 64'(tag_out), 64'(k));
      chk_tol("b2b_res", res_out, b2b_res[k], 1);
      chk("b2b_err", 64'(err_out), 64'(b2b_err[k]));
      @(posedge clk_in);
      #1;
      chk("b2b_vld_clr", 64'(valid_out), 64'd0);
      chk("b2b_rdy",     64'(ready_out), 64'd1);
    end
    valid_in = 1'b0; ready_in = 1'b0;

    // Reset in the middle of the iterations discards the operation.
    @(negedge clk_in);
    a_in = 32'h0002_0000; mode_in = 1'b1; tag_in = 4'd9; valid_in = 1'b1;
    @(posedge clk_in);
    #1 valid_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(ready_out), 64'd1);
    chk("mid_rst_valid", 64'(valid_out), 64'd0);
    chk("mid_rst_res",   64'(res_out),   64'd0);
    chk("mid_rst_err",   64'(err_out),   64'd0);
    chk("mid_rst_tag",   64'(tag_out),   64'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    run_op("post_rst", 32'h0004_0000, 1'b0, 4'd5, 32'h0000_8000, 1, 1'b0, 13, 0);

    repeat (3) @(posedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_inv_sqrt_nr_multi.md
Name: fp_inv_sqrt_nr_multi

Overview:
- Parametrised successor to the folded fixed-point inverse square root used by the ray normaliser and lighting path.
- Computes 1/sqrt(a) or sqrt(a) for signed fixed point, selected per transaction by mode_in.
- Uses one shared multiplier folded over a configurable number of Newton-Raphson iterations.
- Adds a seed LUT after even-shift normalisation, output backpressure, a pass-through tag, saturation and an error flag.

Parameters:
- WIDTH, 32, total bits of a_in/res_out (two's complement).
- FRAC, 16, fractional bits (Q(WIDTH-FRAC).FRAC).
- ITERS, 3, Newton-Raphson iterations (1..4).
- TAG_WIDTH, 4, width of the pass-through tag.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  asynchronous, active-low reset.
- a_in  in  WIDTH  operand.
- mode_in  in  1  0 = 1/sqrt(a), 1 = sqrt(a).
- tag_in  in  TAG_WIDTH  caller tag, returned with the result.
- valid_in  in  1  operand valid.
- ready_out  out  1  block can accept an operand.
- res_out  out  WIDTH  result.
- err_out  out  1  operand invalid (a<0, or a==0 in mode 0).
- tag_out  out  TAG_WIDTH  tag of the current result.
- valid_out  out  1  result valid.
- ready_in  in  1  downstream accepts the result.

Behaviour:
- Reset values (rst_in low, asynchronous):
  - state = IDLE, ready_out = 1.
  - valid_out = 0, res_out = 0, err_out = 0, tag_out = 0.
  - All internal registers are cleared.
  - An in-flight operation is discarded and produces no output.
- Handshake:
  - ready_out = (state==IDLE).
  - An operand is accepted on a rising edge with valid_in && ready_out. a_in, mode_in and tag_in are captured at that edge.
  - valid_out is held high with res_out, err_out and tag_out stable until a rising edge with ready_in high.
  - On that edge the block returns to IDLE, so ready_out is 1 in the following cycle. There is no accept in the same cycle as the output handshake.
- FSM states: IDLE -> NORM -> SEED -> (MUL_YY -> MUL_MYY -> MUL_UPD) x ITERS -> [SQRT_MUL if mode=1] -> DENORM -> DONE -> IDLE.
- Latency from the accept edge to valid_out high is 4 + 3*ITERS + mode cycles (13 for 1/sqrt and 14 for sqrt at the default ITERS=3).
- Error path: for a<0, or a==0 with mode 0, the FSM goes NORM -> DONE. res_out = 0, err_out = 1, latency 2.
- sqrt(0): mode 1 with a==0 gives res_out = 0, err_out = 0, latency 2.
- NORM:
  - p = index of the leading one of a.
  - Choose even s such that m = a shifted by s lies in [1,4) in Q.FRAC.
  - Then 1/sqrt(a) = 1/sqrt(m) * 2^(s/2).
- SEED:
  - y0 = LUT[m[FRAC+1:FRAC-2]], 12 valid entries for m = 1.0 .. 3.75 in 0.25 steps.
  - Each entry = round(2^FRAC / sqrt(m_lo + 0.125)).
- Iteration:
  - t = y*y, then t = m*t, then y = y*(1.5 - t/2).
  - One multiplier is used per cycle.
  - Products are 2*WIDTH bits, rounded to nearest (add 2^(FRAC-1)) and shifted right by FRAC.
- SQRT_MUL: y = m*y.
- DENORM:
  - Shift y by s/2: left for 1/sqrt, right for sqrt (sign of s/2 flips for sqrt).
  - If the result exceeds 2^(WIDTH-1)-1, saturate to that value.
- Inputs are ignored while the FSM is not in IDLE.
- valid_in held high through the output handshake is accepted on the first IDLE cycle.

Test Plan:
- Mode 0, a=0x00010000 (1.0) -> valid_out after 13 cycles, res_out 0x00010000 +/-7 LSB, err_out 0, tag echoed.
- Mode 0, sweep a = 0.25, 0.5, 0.7, 3.7, 4.0, 6.9 -> res_out within 1e-4 of 1/sqrt(a) (0.25 -> 0x00020000, 4.0 -> 0x00008000).
- Mode 0, a=0x00000001 -> res_out 0x01000000 (256.0) +/-1 LSB. Mode 1, a=0x00020000 -> res_out 0x00016A0A +/-7 LSB after 14 cycles.
- a=0xFFFF0000 (-1.0) in mode 0 or 1, and a=0 in mode 0 -> res_out 0, err_out 1, valid_out after 2 cycles. Mode 1, a=0 -> res_out 0, err_out 0.
- Backpressure: ready_in held low for 5 cycles after valid_out -> outputs stable and ready_out 0 throughout. ready_in high -> valid_out 0 and ready_out 1 next cycle. Back-to-back operands with tags 0..3 are returned in order.
- Assert rst_in low mid-iteration (cycle 6) -> outputs immediately at reset values. After release, a=4.0 -> 0x00008000 with normal latency.
